// File: rtl/queue_word_packer.sv
// Pops WIDTH-bit words from an upstream queue and packs PACK of them into one wide beat
// on a valid/ready channel; a flush pulse closes a partially filled beat.
module queue_word_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CW    = $clog2(PACK + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  q_empty,
  input  logic [WIDTH-1:0]      q_data,
  output logic                  q_dequeue,
  input  logic                  flush,
  output logic [PACK*WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_count,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // state     | meaning
  // S_FETCH   | decide: pop a word, close a flushed partial beat, or idle
  // S_CAPTURE | popped word is on q_data; store it in slot cnt
  // S_OUT     | beat presented on out_*; wait for out_ready
  typedef enum logic [1:0] {S_FETCH, S_CAPTURE, S_OUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          flush_pend;
  logic          deq;
  logic          fp_clr;

  always_comb begin
    state_nxt = state;
    deq       = 1'b0;
    fp_clr    = 1'b0;
    case (state)
      S_FETCH: begin
        if (cnt == '0) fp_clr = 1'b1;
        if (cnt == '0 && flush_pend) begin
          state_nxt = S_FETCH;
        end else if (!q_empty) begin
          deq       = 1'b1;
          state_nxt = S_CAPTURE;
        end else if (flush_pend) begin
          state_nxt = S_OUT;
        end
      end
      S_CAPTURE: state_nxt = (cnt == CW'(PACK - 1)) ? S_OUT : S_FETCH;
      S_OUT: begin
        if (out_ready) begin
          state_nxt = S_FETCH;
          fp_clr    = out_last;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Gate with reset so no pop request leaks upstream while the packer is held in reset.
  assign q_dequeue = deq & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      // A flush arriving in the same cycle as a clear is kept as a new request.
      flush_pend <= (flush_pend & ~fp_clr) | flush;
      case (state)
        S_FETCH: begin
          if (state_nxt == S_OUT) begin
            out_count <= cnt;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < PACK; i++) begin
            if (cnt == CW'(i)) out_data[i*WIDTH +: WIDTH] <= q_data;
          end
          cnt <= cnt + CW'(1);
          if (state_nxt == S_OUT) begin
            out_count <= CW'(PACK);
            out_last  <= flush_pend | flush;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
